wb_bus_if: RTL
==============

Name: wb_bus_if

Overview:
- Bridges the CPU's data-memory port (ce/we/addr/sel/data) to a Wishbone B4 classic master bus, replacing the direct CPU-to-data_ram wiring in the SoC top.
- Holds the pipeline with a stall request until the slave acks.
- Buffers read data while the pipeline is stalled by other sources.
- Aborts on pipeline flush or bus timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; sel width is DATA_W/8.
- TIMEOUT, 255, cycles to wait for ack before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_ce_i  in  1  CPU memory access request.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_sel_i  in  DATA_W/8  byte enables.
- cpu_data_i  in  DATA_W  write data.
- cpu_data_o  out  DATA_W  read data to CPU.
- stall_i  in  6  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush (exception).
- stallreq_o  out  1  stall request to ctrl.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- wb_data_i  in  DATA_W  slave read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_addr_o  out  ADDR_W  bus address.
- wb_data_o  out  DATA_W  bus write data.
- wb_we_o  out  1  bus write enable.
- wb_sel_o  out  DATA_W/8  bus byte select.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.

Behaviour:
- **Reset:**
  - Asynchronous, active-high.
  - State = IDLE.
  - All wb_* outputs, rd_buf, timeout counter and bus_err_o = 0.
- **Registered outputs:** wb_* outputs. **Combinational outputs:** stallreq_o and cpu_data_o, decoded from state and inputs.
- **IDLE:**
  - If cpu_ce_i=1 and flush_i=0: register cyc=stb=1 with addr, data, we and sel from the CPU; clear counter; go to BUSY.
  - Combinationally in the same cycle: stallreq_o=1, cpu_data_o=0.
  - Otherwise: stallreq_o=0, cpu_data_o=0.
- **BUSY:**
  - wb_ack_i=1:
    - Deassert cyc/stb; zero addr, data, we and sel.
    - If read, rd_buf <= wb_data_i.
    - Next state is WAIT_FOR_STALL if stall_i != 0, else IDLE.
    - Combinationally: stallreq_o=0; cpu_data_o = wb_data_i for a read, 0 for a write.
  - wb_ack_i=0, flush_i=1:
    - Deassert the bus, rd_buf <= 0, go to IDLE.
    - stallreq_o=1 this cycle; ctrl gives flush priority.
  - wb_ack_i=0, counter reaches TIMEOUT-1 (TIMEOUT != 0):
    - Deassert the bus, bus_err_o <= 1 for one cycle, rd_buf <= 0, go to IDLE.
    - stallreq_o=0, cpu_data_o=0.
  - Otherwise: counter increments; stallreq_o=1, cpu_data_o=0.
  - Ack wins over flush and timeout in the same cycle.
- **WAIT_FOR_STALL:**
  - stallreq_o=0, cpu_data_o=rd_buf.
  - When stall_i == 0, go to IDLE. rd_buf persists until the next ack.
- **Bus rules:**
  - wb_cyc_o == wb_stb_o at all times.
  - One transfer per request; no pipelined or burst transfers.
  - Addr, data, we and sel are stable while stb=1.
- **No-combinational-path rule:** cpu_ce_i deasserting while BUSY does not abort the transfer; only flush, ack or timeout end it.
- **Back-to-back access:** a request asserted in IDLE directly after an ack-to-IDLE starts a new cycle, leaving a single dead bus cycle between transfers.
- **Counter:** width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
- **Reset mid-transfer:** the bus drops immediately, asynchronously.

Test Plan:
1. **Read, ack after 2 cycles:**
   - Stimulus: ce=1, we=0, addr=0x100, sel=0xF, stall_i=0; slave acks with 0xDEADBEEF on the 3rd BUSY cycle.
   - Response: stb high for 3 cycles; stallreq_o=1 until the ack cycle; cpu_data_o=0xDEADBEEF in the ack cycle; back to IDLE.
2. **Write:**
   - Stimulus: ce=1, we=1, addr=0x204, sel=0x3, data=0x1234; ack after 1 cycle.
   - Response: wb_we_o=1, wb_sel_o=0x3, wb_data_o=0x1234 stable while stb=1; cpu_data_o=0; all outputs cleared after the ack.
3. **Read with external stall:**
   - Stimulus: ack delivers 0xA5A5A5A5 while stall_i=6'b000011; stall_i clears 3 cycles later.
   - Response: state WAIT_FOR_STALL; cpu_data_o=0xA5A5A5A5 and stallreq_o=0 for all 3 cycles; then IDLE.
4. **Flush in BUSY:**
   - Stimulus: flush_i=1 on the 2nd BUSY cycle with no ack.
   - Response: stb/cyc=0 next cycle; IDLE; no bus_err_o.
   - Second case: flush_i=1 and ce=1 in IDLE → no cycle started.
5. **Timeout:**
   - Stimulus: TIMEOUT=4, no ack.
   - Response: bus_err_o pulses 1 cycle after 4 BUSY cycles; bus released.
   - Second case: TIMEOUT=0 with no ack for 1000 cycles → still BUSY, no error.
6. **Reset and simultaneity:**
   - Stimulus: rst asserted asynchronously mid-BUSY.
   - Response: all outputs 0 before the next clk edge.
   - Second case: ack+flush in the same cycle → ack honoured, read data delivered.

Source files
------------

// File: rtl/wb_bus_if.sv
// Bridges the CPU data-memory port onto a single-transfer Wishbone B4 classic master.
// The pipeline is stalled until the slave acks; read data is buffered while other stalls persist.
module wb_bus_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  output logic                stallreq_o,
  output logic                bus_err_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o
);

  localparam int SEL_W = DATA_W / 8;
  // A disabled timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  rd_buf;
  logic [CNT_W-1:0]   cnt;
  logic               start;
  logic               timed_out;

  assign start     = cpu_ce_i & ~flush_i;
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf    <= '0;
      cnt       <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wb_addr_o <= cpu_addr_i;
            wb_data_o <= cpu_data_i;
            wb_we_o   <= cpu_we_i;
            wb_sel_o  <= cpu_sel_i;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Ack has priority: a completed transfer is never thrown away by flush or timeout.
          if (wb_ack_i) begin
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            if (!wb_we_o) begin
              rd_buf <= wb_data_i;
            end
            state <= (stall_i != 6'd0) ? WAIT_FOR_STALL : IDLE;
          end else if (flush_i || timed_out) begin
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= '0;
            bus_err_o <= ~flush_i;
            state     <= IDLE;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_FOR_STALL: begin
          if (stall_i == 6'd0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall request and read data are decoded combinationally so the CPU sees ack data in the ack cycle.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state)
        IDLE: stallreq_o = start;
        BUSY: begin
          if (wb_ack_i) begin
            cpu_data_o = wb_we_o ? '0 : wb_data_i;
          end else if (flush_i) begin
            stallreq_o = 1'b1;
          end else if (!timed_out) begin
            stallreq_o = 1'b1;
          end
        end
        WAIT_FOR_STALL: cpu_data_o = rd_buf;
        default: begin
          stallreq_o = 1'b0;
          cpu_data_o = '0;
        end
      endcase
    end
  end

  logic unused_sel_w;
  assign unused_sel_w = (SEL_W == 0);

endmodule
